axi_register_slave: RTL and testbench
=====================================

AXI_REGISTER_SLAVE -- requirements
Module: axi_register_slave

Interface
REQ-001 SHALL have parameter REG_COUNT, default 8, number of 32-bit registers (power of two, 2..64).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of register 0 (aligned to REG_COUNT*4).
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have write-address ports: axi_awaddr_i in AXI_ADDR_SIZE; axi_awvalid_i in 1; axi_awready_o out 1.
REQ-006 SHALL have write-data ports: axi_wdata_i in AXI_DATA_SIZE*8; axi_wstrb_i in AXI_DATA_SIZE; axi_wvalid_i in 1; axi_wready_o out 1.
REQ-007 SHALL have write-response ports: axi_bresp_o out axi_response_t; axi_bvalid_o out 1; axi_bready_i in 1.
REQ-008 SHALL have read-address ports: axi_araddr_i in AXI_ADDR_SIZE; axi_arvalid_i in 1; axi_arready_o out 1.
REQ-009 SHALL have read-data ports: axi_rdata_o out 32; axi_rresp_o out axi_response_t; axi_rvalid_o out 1; axi_rready_i in 1.
REQ-010 SHALL have port registers_o, output, REG_COUNT*32, current contents of all registers (register i at bits [32i+31:32i]).

Function
REQ-011 SHALL act as the AXI4-Lite responder; write and read paths SHALL be independent FSMs operating concurrently.
REQ-012 Write FSM states SHALL be W_IDLE, W_RESP.
REQ-013 In W_IDLE, axi_awready_o SHALL be 1 until AW captured, axi_wready_o SHALL be 1 until W captured; AW and W SHALL be captured independently, in either order or the same cycle.
REQ-014 In the cycle after both AW and W are captured, the register update SHALL commit and the FSM SHALL enter W_RESP with axi_bvalid_o=1.
REQ-015 In W_RESP, awready/wready SHALL be 0; axi_bvalid_o and axi_bresp_o SHALL hold stable until axi_bready_i=1, then return to W_IDLE (next write accepted one cycle later).
REQ-016 Write SHALL update only bytes whose axi_wstrb_i bit is 1; wstrb=4'b0000 SHALL give OKAY with no change.
REQ-017 Read FSM states SHALL be R_IDLE, R_DATA; axi_arready_o=1 in R_IDLE; on AR handshake enter R_DATA next cycle with axi_rvalid_o=1, rdata/rresp registered.
REQ-018 In R_DATA, arready=0; rvalid/rdata/rresp SHALL hold until axi_rready_i=1, then return to R_IDLE.
REQ-019 Decode: offset = addr - BASE_ADDR; offset >= REG_COUNT*4 SHALL give DECERR; in-range with addr[1:0]!=0 SHALL give SLVERR; else OKAY, index = offset[..:2].
REQ-020 Error accesses SHALL not modify any register; error reads SHALL return rdata=32'h0.
REQ-021 Read and write to the same register committing in the same cycle: read SHALL return the pre-write value.
REQ-022 registers_o SHALL reflect a committed write the cycle after commit.

Reset
REQ-023 On rst_n_i=0, SHALL asynchronously clear all registers to 0, both FSMs to IDLE, captured flags to 0.
REQ-024 Reset values: awready=wready=arready=1 after release, bvalid=rvalid=0, bresp=rresp=OKAY, rdata=0, registers_o=0.
REQ-025 Reset mid-transaction SHALL abort it with no response issued and no partial register update.

Structure
REQ-026 axi_response_t, AXI_DATA_SIZE, AXI_ADDR_SIZE SHALL come from axi_interface_pkg; FSM state enums are local to the module.
REQ-027 Address decode (offset, index, response) SHALL be a combinational sub-module axi_address_decoder, instantiated once per channel.

Verification
REQ-028 AW and W same cycle, addr BASE+0x4, data 0xDEADBEEF, strb 4'hF -> bvalid 2 cycles later, OKAY; register 1 = 0xDEADBEEF.
REQ-029 W two cycles before AW, addr BASE+0x8, data 0x11223344, strb 4'b0101 on reg=0 -> reg 2 = 0x00220044, OKAY.
REQ-030 Write BASE+0x20 (REG_COUNT=8) -> DECERR, no register changes; read BASE+0x6 -> SLVERR, rdata 0.
REQ-031 bready held 0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout; next write accepted after handshake.
REQ-032 Read and write reg 3 (old 0x1, new 0x2) committing same cycle -> rdata 0x1; later read -> 0x2.
REQ-033 Assert rst_n_i with AW captured, W pending -> no bvalid, registers unchanged, all ready outputs 1 after release.

Source files
------------

// File: rtl/axi_interface_pkg.sv
// Shared AXI4-Lite widths and response encoding.
package axi_interface_pkg;

   localparam int unsigned AXI_DATA_SIZE = 4;   // bytes per data beat
   localparam int unsigned AXI_ADDR_SIZE = 32;  // address bits

   typedef enum logic [1:0] {
      AXI_OKAY   = 2'b00,
      AXI_EXOKAY = 2'b01,
      AXI_SLVERR = 2'b10,
      AXI_DECERR = 2'b11
   } axi_response_t;

endpackage

// File: rtl/axi_address_decoder.sv
// Combinational register-bank address decode: window check, alignment check
// and register index extraction. One instance serves one AXI channel.
module axi_address_decoder
   import axi_interface_pkg::*;
#(
   parameter int unsigned              REG_COUNT = 8,
   parameter logic [AXI_ADDR_SIZE-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic [AXI_ADDR_SIZE-1:0]     addr,
   output logic [$clog2(REG_COUNT)-1:0] index,
   output axi_response_t                resp
);

   localparam int unsigned IDX_W = $clog2(REG_COUNT);

   // Addresses below the base wrap to a huge offset and fall out of the window.
   logic [AXI_ADDR_SIZE-1:0] offset;
   assign offset = addr - BASE_ADDR;

   // Classify the access and extract the word index.
   always_comb begin
      index = offset[IDX_W+1:2];
      if (offset >= AXI_ADDR_SIZE'(REG_COUNT * 4))
         resp = AXI_DECERR;
      else if (addr[1:0] != 2'b00)
         resp = AXI_SLVERR;
      else
         resp = AXI_OKAY;
   end

endmodule

// File: rtl/axi_register_slave.sv
// AXI4-Lite register bank with independent write and read FSMs.
module axi_register_slave
   import axi_interface_pkg::*;
#(
   parameter int unsigned              REG_COUNT = 8,
   parameter logic [AXI_ADDR_SIZE-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic [AXI_ADDR_SIZE-1:0]     axi_awaddr_i,
   input  logic                         axi_awvalid_i,
   output logic                         axi_awready_o,
   input  logic [AXI_DATA_SIZE*8-1:0]   axi_wdata_i,
   input  logic [AXI_DATA_SIZE-1:0]     axi_wstrb_i,
   input  logic                         axi_wvalid_i,
   output logic                         axi_wready_o,
   output axi_response_t                axi_bresp_o,
   output logic                         axi_bvalid_o,
   input  logic                         axi_bready_i,
   input  logic [AXI_ADDR_SIZE-1:0]     axi_araddr_i,
   input  logic                         axi_arvalid_i,
   output logic                         axi_arready_o,
   output logic [31:0]                  axi_rdata_o,
   output axi_response_t                axi_rresp_o,
   output logic                         axi_rvalid_o,
   input  logic                         axi_rready_i,
   output logic [REG_COUNT*32-1:0]      registers_o
);

   localparam int unsigned IDX_W = $clog2(REG_COUNT);

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   logic [0:0]                 w_state;
   logic [0:0]                 r_state;
   logic                       aw_captured;
   logic                       w_captured;
   logic [AXI_ADDR_SIZE-1:0]   aw_addr;
   logic [AXI_DATA_SIZE*8-1:0] w_data;
   logic [AXI_DATA_SIZE-1:0]   w_strb;
   logic [31:0]                regs [REG_COUNT];

   logic [IDX_W-1:0]           w_index;
   axi_response_t              w_resp;
   logic [IDX_W-1:0]           r_index;
   axi_response_t              r_resp;

   // The write side decodes the captured address, the read side the live one.
   axi_address_decoder #(.REG_COUNT(REG_COUNT), .BASE_ADDR(BASE_ADDR)) u_wdec (
      .addr  (aw_addr),
      .index (w_index),
      .resp  (w_resp)
   );

   axi_address_decoder #(.REG_COUNT(REG_COUNT), .BASE_ADDR(BASE_ADDR)) u_rdec (
      .addr  (axi_araddr_i),
      .index (r_index),
      .resp  (r_resp)
   );

   assign axi_awready_o = (w_state == W_IDLE) && !aw_captured;
   assign axi_wready_o  = (w_state == W_IDLE) && !w_captured;
   assign axi_arready_o = (r_state == R_IDLE);

   // Write channel: capture AW and W independently, commit once both are held.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         w_state      <= W_IDLE;
         aw_captured  <= 1'b0;
         w_captured   <= 1'b0;
         aw_addr      <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         axi_bvalid_o <= 1'b0;
         axi_bresp_o  <= AXI_OKAY;
         for (int unsigned i = 0; i < REG_COUNT; i++)
            regs[i] <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (axi_awvalid_i && axi_awready_o) begin
                  aw_captured <= 1'b1;
                  aw_addr     <= axi_awaddr_i;
               end
               if (axi_wvalid_i && axi_wready_o) begin
                  w_captured <= 1'b1;
                  w_data     <= axi_wdata_i;
                  w_strb     <= axi_wstrb_i;
               end
               if (aw_captured && w_captured) begin
                  if (w_resp == AXI_OKAY) begin
                     for (int unsigned b = 0; b < AXI_DATA_SIZE; b++)
                        if (w_strb[b])
                           regs[w_index][8*b +: 8] <= w_data[8*b +: 8];
                  end
                  aw_captured  <= 1'b0;
                  w_captured   <= 1'b0;
                  axi_bvalid_o <= 1'b1;
                  axi_bresp_o  <= w_resp;
                  w_state      <= W_RESP;
               end
            end
            W_RESP: begin
               if (axi_bready_i) begin
                  axi_bvalid_o <= 1'b0;
                  w_state      <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read channel: register the addressed word on AR handshake, hold until taken.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= R_IDLE;
         axi_rvalid_o <= 1'b0;
         axi_rdata_o  <= '0;
         axi_rresp_o  <= AXI_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (axi_arvalid_i) begin
                  axi_rvalid_o <= 1'b1;
                  axi_rresp_o  <= r_resp;
                  axi_rdata_o  <= (r_resp == AXI_OKAY) ? regs[r_index] : 32'h0;
                  r_state      <= R_DATA;
               end
            end
            R_DATA: begin
               if (axi_rready_i) begin
                  axi_rvalid_o <= 1'b0;
                  r_state      <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Flatten the register array onto the status bus.
   always_comb begin
      registers_o = '0;
      for (int unsigned i = 0; i < REG_COUNT; i++)
         registers_o[32*i +: 32] = regs[i];
   end

endmodule

// File: tb/tb_axi_register_slave.sv
// Scoreboard bench for axi_register_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares on each B/R handshake.
module tb_axi_register_slave;
   import axi_interface_pkg::*;

   localparam logic [31:0] BASE = 32'h4000_0000;

   typedef struct {
      axi_response_t resp;
      logic [31:0]   data;
   } rexp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   awaddr = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          wvalid = 1'b0;
   logic          wready;
   axi_response_t bresp;
   logic          bvalid;
   logic          bready = 1'b1;
   logic [31:0]   araddr = '0;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [31:0]   rdata;
   axi_response_t rresp;
   logic          rvalid;
   logic          rready = 1'b1;
   logic [255:0]  regs_o;

   int total = 0;
   int bad = 0;
   axi_response_t bq[$];
   rexp_t         rq[$];
   logic [31:0]   exp_regs [8];
   axi_response_t mon_b;
   rexp_t         mon_r;

   axi_register_slave #(.REG_COUNT(8), .BASE_ADDR(BASE)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .axi_awaddr_i  (awaddr),
      .axi_awvalid_i (awvalid),
      .axi_awready_o (awready),
      .axi_wdata_i   (wdata),
      .axi_wstrb_i   (wstrb),
      .axi_wvalid_i  (wvalid),
      .axi_wready_o  (wready),
      .axi_bresp_o   (bresp),
      .axi_bvalid_o  (bvalid),
      .axi_bready_i  (bready),
      .axi_araddr_i  (araddr),
      .axi_arvalid_i (arvalid),
      .axi_arready_o (arready),
      .axi_rdata_o   (rdata),
      .axi_rresp_o   (rresp),
      .axi_rvalid_o  (rvalid),
      .axi_rready_i  (rready),
      .registers_o   (regs_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance n cycles, landing 1 time unit after the rising edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_reg%0d", tag, i), regs_o[32*i +: 32], exp_regs[i]);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
         cyc(1);
         n++;
      end
      check("drain", bq.size() + rq.size(), 0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input axi_response_t exp);
      bq.push_back(exp);
      fork
         begin
            logic hs;
            int   n;
            hs = 1'b0;
            n  = 0;
            cyc(aw_dly);
            awaddr  = addr;
            awvalid = 1'b1;
            while (!hs && n < 50) begin
               @(negedge clk);
               hs = awready;
               cyc(1);
               n++;
            end
            awvalid = 1'b0;
            check("aw_handshake", {31'b0, hs}, 1);
         end
         begin
            logic hs;
            int   n;
            hs = 1'b0;
            n  = 0;
            cyc(w_dly);
            wdata  = data;
            wstrb  = strb;
            wvalid = 1'b1;
            while (!hs && n < 50) begin
               @(negedge clk);
               hs = wready;
               cyc(1);
               n++;
            end
            wvalid = 1'b0;
            check("w_handshake", {31'b0, hs}, 1);
         end
      join
   endtask

   task automatic do_read(input logic [31:0] addr, input axi_response_t exp_resp,
                          input logic [31:0] exp_data);
      logic hs;
      int   n;
      rq.push_back('{resp: exp_resp, data: exp_data});
      hs      = 1'b0;
      n       = 0;
      araddr  = addr;
      arvalid = 1'b1;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = arready;
         cyc(1);
         n++;
      end
      arvalid = 1'b0;
      check("ar_handshake", {31'b0, hs}, 1);
   endtask

   // Response monitor: every B/R handshake must match the head of its queue.
   always @(negedge clk) begin
      if (bvalid && bready) begin
         if (bq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_b: got bvalid with bresp %0d, required no response", bresp);
         end else begin
            mon_b = bq.pop_front();
            check("bresp", 32'(bresp), 32'(mon_b));
         end
      end
      if (rvalid && rready) begin
         if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_r: got rvalid with rdata %h, required no response", rdata);
         end else begin
            mon_r = rq.pop_front();
            check("rresp", 32'(rresp), 32'(mon_r.resp));
            check("rdata", rdata, mon_r.data);
         end
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;

      // Reset values
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      check("rst_awready", {31'b0, awready}, 1);
      check("rst_wready",  {31'b0, wready},  1);
      check("rst_arready", {31'b0, arready}, 1);
      check("rst_bvalid",  {31'b0, bvalid},  0);
      check("rst_rvalid",  {31'b0, rvalid},  0);
      check("rst_bresp",   32'(bresp), 32'(AXI_OKAY));
      check("rst_rresp",   32'(rresp), 32'(AXI_OKAY));
      check("rst_rdata",   rdata, 32'h0);
      check_all_regs("rst");

      // AW and W in the same cycle; bvalid two cycles after the handshake
      awaddr  = BASE + 32'h4;
      wdata   = 32'hDEAD_BEEF;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bq.push_back(AXI_OKAY);
      cyc(1);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      @(negedge clk);
      check("b_lat_early", {31'b0, bvalid}, 0);
      check("awready_captured", {31'b0, awready}, 0);
      @(negedge clk);
      check("b_lat_on", {31'b0, bvalid}, 1);
      cyc(1);
      drain();
      exp_regs[1] = 32'hDEAD_BEEF;
      check_all_regs("same_cycle");

      // W two cycles ahead of AW with a sparse strobe
      do_write(BASE + 32'h8, 32'h1122_3344, 4'b0101, 2, 0, AXI_OKAY);
      drain();
      exp_regs[2] = 32'h0022_0044;
      check_all_regs("w_first");

      // Empty strobe and single-byte strobe
      do_write(BASE + 32'h4, 32'h0000_0000, 4'b0000, 0, 0, AXI_OKAY);
      drain();
      check_all_regs("strb_zero");
      do_write(BASE + 32'h4, 32'h0000_00AA, 4'b0001, 0, 1, AXI_OKAY);
      drain();
      exp_regs[1] = 32'hDEAD_BEAA;
      check_all_regs("strb_byte0");

      // Error decode: out of window, misaligned, below base
      do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, AXI_DECERR);
      do_write(BASE + 32'h6,  32'hFFFF_FFFF, 4'hF, 0, 0, AXI_SLVERR);
      drain();
      check_all_regs("err_write");
      do_read(BASE + 32'h6,  AXI_SLVERR, 32'h0);
      do_read(BASE + 32'h20, AXI_DECERR, 32'h0);
      do_read(BASE - 32'h4,  AXI_DECERR, 32'h0);
      do_read(BASE + 32'h4,  AXI_OKAY,   32'hDEAD_BEAA);
      do_read(BASE + 32'h8,  AXI_OKAY,   32'h0022_0044);
      drain();

      // Backpressure on B: response and readies hold while bready is low
      bready = 1'b0;
      do_write(BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, AXI_OKAY);
      begin
         int n;
         n = 0;
         while (!bvalid && n < 20) begin
            cyc(1);
            n++;
         end
      end
      check("bvalid_wait", {31'b0, bvalid}, 1);
      repeat (5) begin
         @(negedge clk);
         check("hold_bvalid",  {31'b0, bvalid}, 1);
         check("hold_bresp",   32'(bresp), 32'(AXI_OKAY));
         check("hold_awready", {31'b0, awready}, 0);
         check("hold_wready",  {31'b0, wready},  0);
      end
      cyc(1);
      bready = 1'b1;
      drain();
      do_write(BASE + 32'h14, 32'h5555_AAAA, 4'hF, 0, 0, AXI_OKAY);
      drain();
      exp_regs[4] = 32'hCAFE_F00D;
      exp_regs[5] = 32'h5555_AAAA;
      check_all_regs("backpressure");
      do_read(BASE + 32'h14, AXI_OKAY, 32'h5555_AAAA);
      drain();

      // Read and write of reg 3 landing on the same edge return the old value
      do_write(BASE + 32'hC, 32'h0000_0001, 4'hF, 0, 0, AXI_OKAY);
      drain();
      awaddr  = BASE + 32'hC;
      wdata   = 32'h0000_0002;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bq.push_back(AXI_OKAY);
      cyc(1);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      araddr  = BASE + 32'hC;
      arvalid = 1'b1;
      rq.push_back('{resp: AXI_OKAY, data: 32'h0000_0001});
      cyc(1);
      arvalid = 1'b0;
      drain();
      exp_regs[3] = 32'h0000_0002;
      check_all_regs("collide");
      do_read(BASE + 32'hC, AXI_OKAY, 32'h0000_0002);
      drain();

      // Reset with AW captured and W still pending
      awaddr  = BASE;
      awvalid = 1'b1;
      cyc(1);
      awvalid = 1'b0;
      check("pend_awready", {31'b0, awready}, 0);
      cyc(1);
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
      check_all_regs("mid_reset");
      check("mrst_awready", {31'b0, awready}, 1);
      check("mrst_wready",  {31'b0, wready},  1);
      check("mrst_arready", {31'b0, arready}, 1);
      check("mrst_bvalid",  {31'b0, bvalid},  0);
      // W alone after reset must not complete the aborted write
      wdata  = 32'h0000_0077;
      wstrb  = 4'hF;
      wvalid = 1'b1;
      cyc(1);
      wvalid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("no_stale_b", {31'b0, bvalid}, 0);
      end
      cyc(1);
      awaddr  = BASE;
      awvalid = 1'b1;
      bq.push_back(AXI_OKAY);
      cyc(1);
      awvalid = 1'b0;
      drain();
      exp_regs[0] = 32'h0000_0077;
      check_all_regs("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
